// File: rtl/am2932_seq_ctl_if.sv
// Request stream and am2932 control bus between the sequencer driver and its master.
// The master drives requests and the slice full_ flag; the slave drives the am2932 word stream.
interface am2932_seq_ctl_if #(
    parameter int unsigned NSLICE = 1
);
    localparam int unsigned W = 4 * NSLICE;

    logic         req_valid;
    logic         req_ready;
    logic [2:0]   req_op;
    logic [W-1:0] req_data;
    logic         busy;
    logic         err;
    logic [4:0]   depth;
    logic [3:0]   i;
    logic [W-1:0] d;
    logic         oe_;
    logic         cn;
    logic         ci;
    logic         full_;

    modport master (
        output req_valid, req_op, req_data, full_,
        input  req_ready, busy, err, depth, i, d, oe_, cn, ci
    );

    modport slave (
        input  req_valid, req_op, req_data, full_,
        output req_ready, busy, err, depth, i, d, oe_, cn, ci
    );
endinterface

// File: rtl/am2932_seq_ctl.sv
// Command-side driver for cascaded am2932 slices: turns fetch/jump/call/return/stack
// requests into one registered am2932 opcode per clock and tracks stack depth locally.
module am2932_seq_ctl #(
    parameter int unsigned NSLICE = 1,
    parameter int unsigned DEPTH  = 17
) (
    input logic             cp,
    input logic             rst_,
    am2932_seq_ctl_if.slave bus
);
    localparam int unsigned W = 4 * NSLICE;
    localparam logic [4:0] DEPTH_MAX = 5'(DEPTH);

    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_LOAD = 2'd2;

    localparam logic [3:0] I_PRST = 4'b0000;
    localparam logic [3:0] I_PSUS = 4'b0001;
    localparam logic [3:0] I_PSHD = 4'b0010;
    localparam logic [3:0] I_POPS = 4'b0011;
    localparam logic [3:0] I_FPC  = 4'b0100;
    localparam logic [3:0] I_JMPD = 4'b0101;
    localparam logic [3:0] I_RTS  = 4'b0111;
    localparam logic [3:0] I_JPPR = 4'b1100;
    localparam logic [3:0] I_JSBR = 4'b1101;
    localparam logic [3:0] I_JSPR = 4'b1110;
    localparam logic [3:0] I_PLDR = 4'b1111;

    localparam logic [2:0] OP_NEXT  = 3'b000;
    localparam logic [2:0] OP_JMP   = 3'b001;
    localparam logic [2:0] OP_BRA   = 3'b010;
    localparam logic [2:0] OP_CALL  = 3'b011;
    localparam logic [2:0] OP_CALLR = 3'b100;
    localparam logic [2:0] OP_RET   = 3'b101;
    localparam logic [2:0] OP_PUSHD = 3'b110;
    localparam logic [2:0] OP_POP   = 3'b111;

    logic [1:0]   state_q, state_d;
    logic [2:0]   op_q, op_d;
    logic [3:0]   i_q, i_d;
    logic [W-1:0] d_q, d_d;
    logic [4:0]   depth_q, depth_d;
    logic         err_q, err_d;
    logic         oe_q, oe_d;
    logic         ci_q, ci_d;
    logic         stk_full, stk_empty;

    assign stk_full  = (depth_q == DEPTH_MAX) || !bus.full_;
    assign stk_empty = (depth_q == 5'd0);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        i_d     = i_q;
        d_d     = d_q;
        depth_d = depth_q;
        err_d   = 1'b0;
        oe_d    = oe_q;
        ci_d    = ci_q;
        case (state_q)
            ST_INIT: begin
                state_d = ST_IDLE;
                i_d     = I_PSUS;
                oe_d    = 1'b0;
                ci_d    = 1'b1;
            end
            ST_IDLE: begin
                // Rejected requests fall through with PSUS already selected.
                i_d = I_PSUS;
                if (bus.req_valid) begin
                    case (bus.req_op)
                        OP_NEXT: i_d = I_FPC;
                        OP_JMP: begin
                            i_d = I_JMPD;
                            d_d = bus.req_data;
                        end
                        OP_RET, OP_POP: begin
                            if (stk_empty) begin
                                err_d = 1'b1;
                            end else begin
                                i_d     = (bus.req_op == OP_RET) ? I_RTS : I_POPS;
                                depth_d = depth_q - 5'd1;
                            end
                        end
                        OP_PUSHD: begin
                            if (stk_full) begin
                                err_d = 1'b1;
                            end else begin
                                i_d     = I_PSHD;
                                d_d     = bus.req_data;
                                depth_d = depth_q + 5'd1;
                            end
                        end
                        default: begin
                            // BRA, CALL, CALLR: load the offset/address register first.
                            if (bus.req_op != OP_BRA && stk_full) begin
                                err_d = 1'b1;
                            end else begin
                                i_d     = I_PLDR;
                                d_d     = bus.req_data;
                                op_d    = bus.req_op;
                                state_d = ST_LOAD;
                            end
                        end
                    endcase
                end
            end
            ST_LOAD: begin
                state_d = ST_IDLE;
                case (op_q)
                    OP_BRA: i_d = I_JPPR;
                    OP_CALL, OP_CALLR: begin
                        i_d = (op_q == OP_CALL) ? I_JSBR : I_JSPR;
                        if (depth_q != DEPTH_MAX) depth_d = depth_q + 5'd1;
                    end
                    default: i_d = I_PSUS;
                endcase
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge cp or negedge rst_) begin
        if (!rst_) begin
            state_q <= ST_INIT;
            op_q    <= OP_NEXT;
            i_q     <= I_PRST;
            d_q     <= '0;
            depth_q <= 5'd0;
            err_q   <= 1'b0;
            oe_q    <= 1'b1;
            ci_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            i_q     <= i_d;
            d_q     <= d_d;
            depth_q <= depth_d;
            err_q   <= err_d;
            oe_q    <= oe_d;
            ci_q    <= ci_d;
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.busy      = (state_q == ST_LOAD);
    assign bus.err       = err_q;
    assign bus.depth     = depth_q;
    assign bus.i         = i_q;
    assign bus.d         = d_q;
    assign bus.oe_       = oe_q;
    assign bus.ci        = ci_q;
    assign bus.cn        = 1'b0;
endmodule
